// File: rtl/flash_arbiter_if.sv
// Bundle of the two requester ports and the flash-controller request/response
// signals used by flash_arbiter.
//
// Handshake: a requester raises pN_stb_i with its address, data and qualifiers
// stable and keeps everything held until it sees a one-cycle pN_ack_o or
// pN_err_o, then drops pN_stb_i. Toward the flash, fl_stb_o stays high with
// stable fl_adr_o/fl_dat_o/fl_we_o/fl_tga_o until the controller answers with a
// one-cycle fl_ack_i (done, fl_dat_i valid) or fl_rty_i (busy, try later).
interface flash_arbiter_if;
  logic [23:0] p0_adr_i;
  logic [31:0] p0_dat_i;
  logic        p0_we_i;
  logic        p0_tga_i;
  logic        p0_stb_i;
  logic [31:0] p0_dat_o;
  logic        p0_ack_o;
  logic        p0_err_o;

  logic [23:0] p1_adr_i;
  logic [31:0] p1_dat_i;
  logic        p1_we_i;
  logic        p1_tga_i;
  logic        p1_stb_i;
  logic [31:0] p1_dat_o;
  logic        p1_ack_o;
  logic        p1_err_o;

  logic [23:0] fl_adr_o;
  logic [31:0] fl_dat_o;
  logic        fl_we_o;
  logic        fl_tga_o;
  logic        fl_stb_o;
  logic [31:0] fl_dat_i;
  logic        fl_ack_i;
  logic        fl_rty_i;

  logic        busy_o;

  // Arbiter side
  modport slave (
    input  p0_adr_i, p0_dat_i, p0_we_i, p0_tga_i, p0_stb_i,
    input  p1_adr_i, p1_dat_i, p1_we_i, p1_tga_i, p1_stb_i,
    input  fl_dat_i, fl_ack_i, fl_rty_i,
    output p0_dat_o, p0_ack_o, p0_err_o,
    output p1_dat_o, p1_ack_o, p1_err_o,
    output fl_adr_o, fl_dat_o, fl_we_o, fl_tga_o, fl_stb_o,
    output busy_o
  );

  // Requester / flash-controller side
  modport master (
    output p0_adr_i, p0_dat_i, p0_we_i, p0_tga_i, p0_stb_i,
    output p1_adr_i, p1_dat_i, p1_we_i, p1_tga_i, p1_stb_i,
    output fl_dat_i, fl_ack_i, fl_rty_i,
    input  p0_dat_o, p0_ack_o, p0_err_o,
    input  p1_dat_o, p1_ack_o, p1_err_o,
    input  fl_adr_o, fl_dat_o, fl_we_o, fl_tga_o, fl_stb_o,
    input  busy_o
  );
endinterface

// File: rtl/flash_arbiter.sv
// Two-port round-robin arbiter in front of a flash controller.
// A granted request is latched into the fl_* registers and presented until the
// controller acks. A retry response idles the flash for RETRY_WAIT cycles and
// then re-presents the same request; after MAX_RETRIES retries the requester
// gets an error pulse. A requester that withdraws mid-transaction does not
// abort the flash operation; its result is simply not reported.
module flash_arbiter #(
  parameter int RETRY_WAIT  = 10000,
  parameter int MAX_RETRIES = 4000
) (
  input  logic           clk_i,
  input  logic           rst_i,
  flash_arbiter_if.slave bus,
  output logic [1:0]     dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

  // wait_cnt counts down to zero, so the idle gap is exactly RETRY_WAIT cycles
  localparam logic [15:0] WAIT_LOAD   = 16'(RETRY_WAIT - 1);
  localparam logic [15:0] RETRY_LIMIT = 16'(MAX_RETRIES);

  state_t      state;
  logic        last_grant;
  logic        grant;
  logic [15:0] retry_cnt;
  logic [15:0] wait_cnt;

  logic [23:0] fl_adr;
  logic [31:0] fl_dat;
  logic        fl_we;
  logic        fl_tga;
  logic        fl_stb;

  logic [31:0] p0_dat;
  logic [31:0] p1_dat;
  logic        p0_ack;
  logic        p0_err;
  logic        p1_ack;
  logic        p1_err;
  logic        busy;

  logic        req_any;
  logic        pick;
  logic [15:0] retry_next;
  logic        last_retry;

  // Arbitration choice and retry-limit detection
  always_comb begin
    req_any    = bus.p0_stb_i | bus.p1_stb_i;
    pick       = 1'b0;
    if (bus.p0_stb_i && bus.p1_stb_i) begin
      pick = ~last_grant;
    end else begin
      pick = bus.p1_stb_i;
    end
    retry_next = retry_cnt + 16'd1;
    last_retry = (retry_next == RETRY_LIMIT);
  end

  // Main FSM with registered outputs; ack/err are one-cycle pulses in RESP
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      grant      <= 1'b0;
      retry_cnt  <= '0;
      wait_cnt   <= '0;
      fl_adr     <= '0;
      fl_dat     <= '0;
      fl_we      <= 1'b0;
      fl_tga     <= 1'b0;
      fl_stb     <= 1'b0;
      p0_dat     <= '0;
      p1_dat     <= '0;
      p0_ack     <= 1'b0;
      p0_err     <= 1'b0;
      p1_ack     <= 1'b0;
      p1_err     <= 1'b0;
      busy       <= 1'b0;
    end else begin
      p0_ack <= 1'b0;
      p0_err <= 1'b0;
      p1_ack <= 1'b0;
      p1_err <= 1'b0;
      case (state)
        IDLE: begin
          if (req_any) begin
            grant      <= pick;
            last_grant <= pick;
            fl_adr     <= pick ? bus.p1_adr_i : bus.p0_adr_i;
            fl_dat     <= pick ? bus.p1_dat_i : bus.p0_dat_i;
            fl_we      <= pick ? bus.p1_we_i  : bus.p0_we_i;
            fl_tga     <= pick ? bus.p1_tga_i : bus.p0_tga_i;
            retry_cnt  <= '0;
            fl_stb     <= 1'b1;
            busy       <= 1'b1;
            state      <= REQ;
          end
        end
        REQ: begin
          if (bus.fl_ack_i) begin
            // Data is captured even for a withdrawn requester; only the
            // ack pulse is suppressed.
            if (grant) begin
              p1_dat <= bus.fl_dat_i;
            end else begin
              p0_dat <= bus.fl_dat_i;
            end
            p0_ack <= ~grant & bus.p0_stb_i;
            p1_ack <=  grant & bus.p1_stb_i;
            fl_stb <= 1'b0;
            state  <= RESP;
          end else if (bus.fl_rty_i) begin
            retry_cnt <= retry_next;
            fl_stb    <= 1'b0;
            if (last_retry) begin
              p0_err <= ~grant & bus.p0_stb_i;
              p1_err <=  grant & bus.p1_stb_i;
              state  <= RESP;
            end else begin
              wait_cnt <= WAIT_LOAD;
              state    <= WAIT;
            end
          end
        end
        WAIT: begin
          if (wait_cnt == 16'd0) begin
            fl_stb <= 1'b1;
            state  <= REQ;
          end else begin
            wait_cnt <= wait_cnt - 16'd1;
          end
        end
        RESP: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          fl_stb <= 1'b0;
          busy   <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.fl_adr_o = fl_adr;
  assign bus.fl_dat_o = fl_dat;
  assign bus.fl_we_o  = fl_we;
  assign bus.fl_tga_o = fl_tga;
  assign bus.fl_stb_o = fl_stb;
  assign bus.p0_dat_o = p0_dat;
  assign bus.p1_dat_o = p1_dat;
  assign bus.p0_ack_o = p0_ack;
  assign bus.p0_err_o = p0_err;
  assign bus.p1_ack_o = p1_ack;
  assign bus.p1_err_o = p1_err;
  assign bus.busy_o   = busy;
  assign dbg_state    = state;

  // The flash request is presented exactly while the FSM is in REQ
  a_stb_in_req: assert property (@(posedge clk_i) disable iff (rst_i)
    fl_stb == (state == REQ));

  // busy mirrors "not IDLE"
  a_busy_state: assert property (@(posedge clk_i) disable iff (rst_i)
    busy == (state != IDLE));

  // At most one completion pulse at a time, and only in RESP
  a_one_pulse: assert property (@(posedge clk_i) disable iff (rst_i)
    $onehot0({p0_ack, p0_err, p1_ack, p1_err}));
  a_pulse_in_resp: assert property (@(posedge clk_i) disable iff (rst_i)
    (p0_ack | p0_err | p1_ack | p1_err) |-> (state == RESP));

endmodule

// File: tb/tb_flash_arbiter.sv
// Bench for flash_arbiter: directed scenarios plus randomized rounds, with a
// behavioural flash-controller model and a round-robin reference model.
module tb_flash_arbiter;

  localparam int RW   = 16;
  localparam int MR   = 5;
  localparam int BUDG = 2000;

  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;
  int         cyc = 0;

  flash_arbiter_if bus ();

  flash_arbiter #(.RETRY_WAIT(RW), .MAX_RETRIES(MR)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- reference-model state ----------------
  int          rr_last = 1;
  logic [31:0] exp_q[$];
  int          exp_port_q[$];
  logic [31:0] exp_p0_dat;

  // Round-robin rule: a tie goes to the port not served last
  function automatic int rr_pick(input bit r0, input bit r1);
    if (r0 && r1) return (rr_last == 0) ? 1 : 0;
    return r1 ? 1 : 0;
  endfunction

  function automatic logic [31:0] flash_fn(input logic [23:0] a);
    return {a[7:0], a} ^ 32'h5A3C_96E1;
  endfunction

  // ---------------- flash controller model ----------------
  int          model_latency = 1;
  int          model_rty     = 0;
  bit          model_always_rty = 1'b0;
  bit          model_fixed   = 1'b0;
  logic [31:0] model_data    = 32'h0;
  int          t_fl_ack      = -100;

  initial begin
    int wait_ctr;
    int phase_idx;
    wait_ctr  = 0;
    phase_idx = 0;
    bus.fl_ack_i = 1'b0;
    bus.fl_rty_i = 1'b0;
    bus.fl_dat_i = 32'h0;
    forever begin
      @(negedge clk);
      bus.fl_ack_i = 1'b0;
      bus.fl_rty_i = 1'b0;
      if (rst || bus.busy_o !== 1'b1) begin
        wait_ctr  = 0;
        phase_idx = 0;
      end else if (bus.fl_stb_o === 1'b1) begin
        if (wait_ctr == model_latency) begin
          if (model_always_rty || phase_idx < model_rty) begin
            bus.fl_rty_i = 1'b1;
          end else begin
            bus.fl_ack_i = 1'b1;
            bus.fl_dat_i = model_fixed ? model_data : flash_fn(bus.fl_adr_o);
            t_fl_ack     = cyc;
          end
          phase_idx++;
        end
        wait_ctr++;
      end else begin
        wait_ctr = 0;
      end
    end
  end

  // ---------------- monitor ----------------
  int          bursts, ack0_cnt, ack1_cnt, err0_cnt, err1_cnt, low_run;
  int          gap_q[$];
  int          act_port_q[$];
  logic [31:0] act_dat_q[$];
  int          t_p_ack;
  bit          prev_stb;
  int          clr_seq = 0;

  initial begin
    int clr_seen;
    clr_seen = 0;
    bursts = 0; ack0_cnt = 0; ack1_cnt = 0; err0_cnt = 0; err1_cnt = 0;
    low_run = 0; t_p_ack = -200; prev_stb = 1'b0;
    forever begin
      @(negedge clk);
      if (clr_seq != clr_seen) begin
        clr_seen = clr_seq;
        bursts = 0; ack0_cnt = 0; ack1_cnt = 0; err0_cnt = 0; err1_cnt = 0;
        low_run = 0;
        gap_q.delete();
        act_port_q.delete();
        act_dat_q.delete();
      end
      if (bus.fl_stb_o === 1'b1 && !prev_stb) begin
        bursts++;
        if (low_run > 0) gap_q.push_back(low_run);
        low_run = 0;
      end
      if (bus.busy_o !== 1'b1) low_run = 0;
      else if (bus.fl_stb_o === 1'b0) low_run++;
      if (bus.p0_ack_o === 1'b1) begin
        ack0_cnt++; t_p_ack = cyc;
        act_port_q.push_back(0); act_dat_q.push_back(bus.p0_dat_o);
      end
      if (bus.p1_ack_o === 1'b1) begin
        ack1_cnt++; t_p_ack = cyc;
        act_port_q.push_back(1); act_dat_q.push_back(bus.p1_dat_o);
      end
      if (bus.p0_err_o === 1'b1) err0_cnt++;
      if (bus.p1_err_o === 1'b1) err1_cnt++;
      prev_stb = (bus.fl_stb_o === 1'b1);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_mon();
    clr_seq++;
    exp_q.delete();
    exp_port_q.delete();
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    bus.p0_stb_i = 1'b0;
    bus.p1_stb_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    rr_last = 1;
  endtask

  task automatic start_req(input int p, input logic [23:0] adr, input logic [31:0] dat,
                           input logic we, input logic tga);
    if (p == 0) begin
      bus.p0_adr_i = adr; bus.p0_dat_i = dat; bus.p0_we_i = we; bus.p0_tga_i = tga;
      bus.p0_stb_i = 1'b1;
    end else begin
      bus.p1_adr_i = adr; bus.p1_dat_i = dat; bus.p1_we_i = we; bus.p1_tga_i = tga;
      bus.p1_stb_i = 1'b1;
    end
  endtask

  // Hold stb until this port's ack or err, then drop it
  task automatic wait_done(input int p, output bit timeout);
    timeout = 1'b1;
    for (int i = 0; i < BUDG; i++) begin
      @(negedge clk);
      if (p == 0 && (bus.p0_ack_o === 1'b1 || bus.p0_err_o === 1'b1)) begin
        timeout = 1'b0; break;
      end
      if (p == 1 && (bus.p1_ack_o === 1'b1 || bus.p1_err_o === 1'b1)) begin
        timeout = 1'b0; break;
      end
    end
    if (p == 0) bus.p0_stb_i = 1'b0;
    else        bus.p1_stb_i = 1'b0;
  endtask

  task automatic wait_stb(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.fl_stb_o === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
    n_tests++; if (bus.fl_stb_o !== 1'b0 || bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_stb_busy got=%b%b exp=00", bus.fl_stb_o, bus.busy_o); end
    n_tests++; if ({bus.p0_ack_o, bus.p0_err_o, bus.p1_ack_o, bus.p1_err_o} !== 4'b0) begin n_fail++; $display("FAIL reset_pulses got=%b%b%b%b exp=0000", bus.p0_ack_o, bus.p0_err_o, bus.p1_ack_o, bus.p1_err_o); end
    n_tests++; if (bus.fl_adr_o !== 24'h0 || bus.fl_dat_o !== 32'h0 || bus.p0_dat_o !== 32'h0 || bus.p1_dat_o !== 32'h0) begin n_fail++; $display("FAIL reset_regs adr=%h fdat=%h d0=%h d1=%h exp=0", bus.fl_adr_o, bus.fl_dat_o, bus.p0_dat_o, bus.p1_dat_o); end
    @(posedge clk); #1 rst = 1'b0;
    rr_last = 1;
  endtask

  task automatic test_single_read();
    bit ok, to;
    int t_req;
    clear_mon();
    model_latency = 40; model_rty = 0; model_fixed = 1'b1; model_data = 32'hDEADBEEF;
    @(posedge clk); #1;
    t_req = cyc;
    start_req(0, 24'h001000, 32'h0, 1'b0, 1'b0);
    wait_stb(ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL read_stb_seen got=0 exp=1"); end
    n_tests++; if (cyc !== t_req + 1) begin n_fail++; $display("FAIL read_grant_latency got=%0d exp=1", cyc - t_req); end
    n_tests++; if (bus.fl_adr_o !== 24'h001000 || bus.fl_we_o !== 1'b0 || bus.fl_tga_o !== 1'b0 || bus.busy_o !== 1'b1) begin n_fail++; $display("FAIL read_latch adr=%h we=%b tga=%b busy=%b exp=001000,0,0,1", bus.fl_adr_o, bus.fl_we_o, bus.fl_tga_o, bus.busy_o); end
    wait_done(0, to);
    n_tests++; if (to) begin n_fail++; $display("FAIL read_timeout got=timeout exp=ack"); end
    repeat (3) @(negedge clk);
    n_tests++; if (ack0_cnt !== 1 || err0_cnt !== 0 || ack1_cnt !== 0 || err1_cnt !== 0) begin n_fail++; $display("FAIL read_pulses a0=%0d e0=%0d a1=%0d e1=%0d exp=1,0,0,0", ack0_cnt, err0_cnt, ack1_cnt, err1_cnt); end
    n_tests++; if (bus.p0_dat_o !== 32'hDEADBEEF) begin n_fail++; $display("FAIL read_data got=%h exp=deadbeef", bus.p0_dat_o); end
    n_tests++; if (bursts !== 1) begin n_fail++; $display("FAIL read_bursts got=%0d exp=1", bursts); end
    n_tests++; if (t_p_ack - t_fl_ack !== 1) begin n_fail++; $display("FAIL read_ack_latency got=%0d exp=1", t_p_ack - t_fl_ack); end
    n_tests++; if (dbg_state !== 2'd0 || bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL read_idle state=%0d busy=%b exp=0,0", dbg_state, bus.busy_o); end
    rr_last = 0;
    model_fixed = 1'b0;
  endtask

  task automatic test_tie();
    bit to0a, to0b, to1;
    int first, second;
    do_reset();
    clear_mon();
    model_latency = 3; model_rty = 0;
    first = rr_pick(1'b1, 1'b1); rr_last = first;
    second = rr_pick(1'b1, 1'b1); rr_last = second;
    exp_port_q = '{first, second, first};
    exp_q.push_back(flash_fn(first == 0 ? 24'h000100 : 24'h000200));
    exp_q.push_back(flash_fn(second == 0 ? 24'h000100 : 24'h000200));
    exp_q.push_back(flash_fn(24'h000104));
    rr_last = 0;
    @(posedge clk); #1;
    start_req(0, 24'h000100, 32'h0, 1'b0, 1'b0);
    start_req(1, 24'h000200, 32'h0, 1'b0, 1'b0);
    fork
      begin
        wait_done(0, to0a);
        @(posedge clk); #1;
        start_req(0, 24'h000104, 32'h0, 1'b0, 1'b0);
        wait_done(0, to0b);
      end
      wait_done(1, to1);
    join
    repeat (3) @(negedge clk);
    n_tests++; if (to0a || to0b || to1) begin n_fail++; $display("FAIL tie_timeout got=%b%b%b exp=000", to0a, to0b, to1); end
    n_tests++; if (act_port_q.size() !== 3) begin n_fail++; $display("FAIL tie_count got=%0d exp=3", act_port_q.size()); end
    else begin
      for (int i = 0; i < 3; i++) begin
        n_tests++; if (act_port_q[i] !== exp_port_q[i] || act_dat_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL tie_order[%0d] got=p%0d/%h exp=p%0d/%h", i, act_port_q[i], act_dat_q[i], exp_port_q[i], exp_q[i]); end
      end
    end
    exp_p0_dat = flash_fn(24'h000104);
  endtask

  task automatic test_erase_retry();
    bit ok, to;
    clear_mon();
    model_latency = 2; model_rty = 3;
    @(posedge clk); #1;
    start_req(1, 24'h020000, 32'h0, 1'b1, 1'b1);
    wait_stb(ok);
    n_tests++; if (!ok || bus.fl_adr_o !== 24'h020000 || bus.fl_we_o !== 1'b1 || bus.fl_tga_o !== 1'b1) begin n_fail++; $display("FAIL erase_latch ok=%b adr=%h we=%b tga=%b exp=1,020000,1,1", ok, bus.fl_adr_o, bus.fl_we_o, bus.fl_tga_o); end
    wait_done(1, to);
    repeat (3) @(negedge clk);
    n_tests++; if (to) begin n_fail++; $display("FAIL erase_timeout got=timeout exp=ack"); end
    n_tests++; if (bursts !== 4) begin n_fail++; $display("FAIL erase_bursts got=%0d exp=4", bursts); end
    n_tests++; if (gap_q.size() !== 3) begin n_fail++; $display("FAIL erase_gap_count got=%0d exp=3", gap_q.size()); end
    foreach (gap_q[i]) begin
      n_tests++; if (gap_q[i] !== RW) begin n_fail++; $display("FAIL erase_gap[%0d] got=%0d exp=%0d", i, gap_q[i], RW); end
    end
    n_tests++; if (ack1_cnt !== 1 || err1_cnt !== 0 || bus.p1_dat_o !== flash_fn(24'h020000)) begin n_fail++; $display("FAIL erase_p1 ack=%0d err=%0d dat=%h exp=1,0,%h", ack1_cnt, err1_cnt, bus.p1_dat_o, flash_fn(24'h020000)); end
    n_tests++; if (ack0_cnt !== 0 || err0_cnt !== 0 || bus.p0_dat_o !== exp_p0_dat) begin n_fail++; $display("FAIL erase_p0_untouched ack=%0d err=%0d dat=%h exp=0,0,%h", ack0_cnt, err0_cnt, bus.p0_dat_o, exp_p0_dat); end
    rr_last = 1;
    model_rty = 0;
  endtask

  task automatic test_max_retries();
    bit to;
    clear_mon();
    model_latency = 1; model_always_rty = 1'b1;
    @(posedge clk); #1;
    start_req(0, 24'h003000, 32'h1234_5678, 1'b1, 1'b0);
    wait_done(0, to);
    repeat (3) @(negedge clk);
    n_tests++; if (to) begin n_fail++; $display("FAIL maxrty_timeout got=timeout exp=err"); end
    n_tests++; if (bursts !== MR) begin n_fail++; $display("FAIL maxrty_bursts got=%0d exp=%0d", bursts, MR); end
    n_tests++; if (err0_cnt !== 1 || ack0_cnt !== 0 || ack1_cnt !== 0 || err1_cnt !== 0) begin n_fail++; $display("FAIL maxrty_pulses e0=%0d a0=%0d a1=%0d e1=%0d exp=1,0,0,0", err0_cnt, ack0_cnt, ack1_cnt, err1_cnt); end
    n_tests++; if (dbg_state !== 2'd0 || bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL maxrty_idle state=%0d busy=%b exp=0,0", dbg_state, bus.busy_o); end
    model_always_rty = 1'b0;
    rr_last = 0;
  endtask

  task automatic test_reset_wait();
    bit ok, to;
    clear_mon();
    model_latency = 1; model_always_rty = 1'b1;
    @(posedge clk); #1;
    start_req(0, 24'h004000, 32'h0, 1'b1, 1'b1);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (dbg_state === 2'd2) begin ok = 1'b1; break; end
    end
    n_tests++; if (!ok) begin n_fail++; $display("FAIL rstwait_reach got=%0d exp=2", dbg_state); end
    @(posedge clk); #1;
    rst = 1'b1;
    bus.p0_stb_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_tests++; if (bus.fl_stb_o !== 1'b0 || bus.busy_o !== 1'b0 || dbg_state !== 2'd0) begin n_fail++; $display("FAIL rstwait_outputs stb=%b busy=%b state=%0d exp=0,0,0", bus.fl_stb_o, bus.busy_o, dbg_state); end
    n_tests++; if ({bus.p0_ack_o, bus.p0_err_o, bus.p1_ack_o, bus.p1_err_o} !== 4'b0 || bus.p0_dat_o !== 32'h0 || bus.fl_adr_o !== 24'h0) begin n_fail++; $display("FAIL rstwait_regs pulses=%b%b%b%b d0=%h adr=%h exp=0", bus.p0_ack_o, bus.p0_err_o, bus.p1_ack_o, bus.p1_err_o, bus.p0_dat_o, bus.fl_adr_o); end
    @(posedge clk); #1 rst = 1'b0;
    rr_last = 1;
    model_always_rty = 1'b0;
    clear_mon();
    @(posedge clk); #1;
    start_req(0, 24'h004100, 32'h0, 1'b0, 1'b0);
    wait_done(0, to);
    repeat (3) @(negedge clk);
    n_tests++; if (to || ack0_cnt !== 1 || bus.p0_dat_o !== flash_fn(24'h004100) || bursts !== 1) begin n_fail++; $display("FAIL rstwait_fresh to=%b ack=%0d dat=%h bursts=%0d exp=0,1,%h,1", to, ack0_cnt, bus.p0_dat_o, bursts, flash_fn(24'h004100)); end
    rr_last = 0;
  endtask

  task automatic test_drop();
    bit ok, to;
    clear_mon();
    model_latency = 20; model_rty = 0;
    @(posedge clk); #1;
    start_req(0, 24'h005000, 32'hCAFE_0000, 1'b1, 1'b0);
    wait_stb(ok);
    start_req(1, 24'h006000, 32'h0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    bus.p0_stb_i = 1'b0;
    @(negedge clk);
    n_tests++; if (!ok || bus.fl_stb_o !== 1'b1 || bus.fl_adr_o !== 24'h005000) begin n_fail++; $display("FAIL drop_held ok=%b stb=%b adr=%h exp=1,1,005000", ok, bus.fl_stb_o, bus.fl_adr_o); end
    wait_done(1, to);
    repeat (3) @(negedge clk);
    n_tests++; if (to) begin n_fail++; $display("FAIL drop_timeout got=timeout exp=ack"); end
    n_tests++; if (ack0_cnt !== 0 || err0_cnt !== 0) begin n_fail++; $display("FAIL drop_p0_silent ack=%0d err=%0d exp=0,0", ack0_cnt, err0_cnt); end
    n_tests++; if (ack1_cnt !== 1 || bus.p1_dat_o !== flash_fn(24'h006000) || bursts !== 2) begin n_fail++; $display("FAIL drop_p1_next ack=%0d dat=%h bursts=%0d exp=1,%h,2", ack1_cnt, bus.p1_dat_o, bursts, flash_fn(24'h006000)); end
    rr_last = 1;
  endtask

  task automatic test_random();
    logic [1:0]  mask;
    logic [23:0] a0, a1;
    bit          to0, to1;
    int          first, n_txn;
    do_reset();
    for (int r = 0; r < 10; r++) begin
      clear_mon();
      mask = 2'($urandom_range(1, 3));
      model_latency = $urandom_range(0, 5);
      model_rty     = $urandom_range(0, 2);
      a0 = 24'($urandom()); a1 = 24'($urandom());
      to0 = 1'b0; to1 = 1'b0;
      first = rr_pick(mask[0], mask[1]);
      exp_port_q.push_back(first);
      exp_q.push_back(flash_fn(first == 0 ? a0 : a1));
      rr_last = first;
      n_txn = 1;
      if (mask == 2'b11) begin
        exp_port_q.push_back(1 - first);
        exp_q.push_back(flash_fn(first == 0 ? a1 : a0));
        rr_last = 1 - first;
        n_txn = 2;
      end
      @(posedge clk); #1;
      if (mask[0]) start_req(0, a0, 32'($urandom()), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if (mask[1]) start_req(1, a1, 32'($urandom()), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      fork
        begin if (mask[0]) wait_done(0, to0); end
        begin if (mask[1]) wait_done(1, to1); end
      join
      repeat (3) @(negedge clk);
      n_tests++; if (to0 || to1 || act_port_q.size() !== exp_port_q.size()) begin n_fail++; $display("FAIL rand[%0d]_count to=%b%b got=%0d exp=%0d", r, to0, to1, act_port_q.size(), exp_port_q.size()); end
      else begin
        foreach (exp_port_q[i]) begin
          n_tests++; if (act_port_q[i] !== exp_port_q[i] || act_dat_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rand[%0d]_txn[%0d] got=p%0d/%h exp=p%0d/%h", r, i, act_port_q[i], act_dat_q[i], exp_port_q[i], exp_q[i]); end
        end
      end
      n_tests++; if (gap_q.size() !== model_rty * n_txn || err0_cnt + err1_cnt !== 0) begin n_fail++; $display("FAIL rand[%0d]_retries gaps=%0d errs=%0d exp=%0d,0", r, gap_q.size(), err0_cnt + err1_cnt, model_rty * n_txn); end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b1;
    bus.p0_adr_i = '0; bus.p0_dat_i = '0; bus.p0_we_i = 1'b0; bus.p0_tga_i = 1'b0; bus.p0_stb_i = 1'b0;
    bus.p1_adr_i = '0; bus.p1_dat_i = '0; bus.p1_we_i = 1'b0; bus.p1_tga_i = 1'b0; bus.p1_stb_i = 1'b0;
    test_reset();
    test_single_read();
    test_tie();
    test_erase_retry();
    test_max_retries();
    test_reset_wait();
    test_drop();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/flash_arbiter.md
FLASH_ARBITER -- requirements
Module: flash_arbiter

Parameters
REQ-001 SHALL have parameter RETRY_WAIT, default 10000, meaning clk_i cycles to idle between a retry response and the next flash attempt.
REQ-002 SHALL have parameter MAX_RETRIES, default 4000, meaning the number of retry responses tolerated per transaction before an error is reported.

Interface
REQ-003 clk_i  in  1  100 MHz system clock; one clock domain, everything updates on its rising edge.
REQ-004 rst_i  in  1  reset, synchronous, active-high.
REQ-005 pN_adr_i  in  24  port N flash byte address (N = 0, 1; all pN_ signals are per port).
REQ-006 pN_dat_i  in  32  port N write data.
REQ-007 pN_we_i  in  1  port N write.
REQ-008 pN_tga_i  in  1  port N erase qualifier; with pN_we_i high, erases the sector.
REQ-009 pN_stb_i  in  1  port N request, held high until pN_ack_o or pN_err_o.
REQ-010 pN_dat_o  out  32  port N read data, valid while pN_ack_o is high.
REQ-011 pN_ack_o  out  1  port N completion pulse.
REQ-012 pN_err_o  out  1  port N timeout pulse.
REQ-013 fl_adr_o, fl_dat_o, fl_we_o, fl_tga_o, fl_stb_o  out  24/32/1/1/1  request to the flash controller.
REQ-014 fl_dat_i, fl_ack_i, fl_rty_i  in  32/1/1  response from the flash controller.
REQ-015 busy_o  out  1  high in every state except IDLE.

Function
REQ-016 The FSM SHALL have the states IDLE, REQ, WAIT and RESP, encoded in 2 bits.
REQ-017 Arbitration in IDLE:
- with one pN_stb_i high, that port SHALL be granted;
- with both high, the port other than last_grant SHALL be granted (round-robin);
- last_grant SHALL reset to 1, so port 0 wins the first tie.
REQ-018 On grant, the arbiter SHALL:
- latch pN_adr_i, pN_dat_i, pN_we_i and pN_tga_i into the fl_*_o registers;
- record the granted port in last_grant;
- clear retry_cnt;
- move to REQ.
REQ-019 In REQ, fl_stb_o SHALL be 1, and fl_stb_o SHALL be 0 in every other state.
REQ-020 In REQ, fl_ack_i high SHALL capture fl_dat_i into the granted port's pN_dat_o register and move to RESP.
REQ-021 In REQ, fl_rty_i high with fl_ack_i low SHALL:
- increment retry_cnt (16 bits);
- load wait_cnt with RETRY_WAIT-1;
- move to WAIT.
REQ-022 A retry that makes retry_cnt equal MAX_RETRIES SHALL instead move to RESP with the error flag set.
REQ-023 If fl_ack_i and fl_rty_i are high in the same cycle, ack SHALL take precedence.
REQ-024 In WAIT, wait_cnt SHALL decrement each cycle, and the FSM SHALL return to REQ the cycle after wait_cnt reaches 0, with the latched fl_* fields unchanged.
REQ-025 RESP SHALL last exactly one cycle, during which the granted port sees:
- pN_ack_o = 1 if there is no error;
- otherwise pN_err_o = 1;
- this output only if that port's pN_stb_i is still high.
REQ-026 RESP SHALL then go to IDLE.
REQ-027 The non-granted port's ack and err SHALL stay 0 throughout.
REQ-028 If the granted port drops pN_stb_i mid-transaction, the flash transaction SHALL still run to completion (no abort of a write or erase), and its result SHALL be discarded.
REQ-029 A port whose pN_stb_i is still high in the cycle after its RESP SHALL be treated as a new request; the requester must drop stb after ack.
REQ-030 Latency: grant-to-fl_stb_o is 1 cycle, and fl_ack_i-to-pN_ack_o is 1 cycle.
REQ-031 No port SHALL be granted more than twice in a row while the other port is requesting.

Reset
REQ-032 With rst_i high at a clock edge, the arbiter SHALL enter IDLE on that edge.
REQ-033 On that edge, these outputs SHALL go to 0: fl_stb_o, all pN_ack_o, all pN_err_o and busy_o.
REQ-034 On that edge, these registers SHALL go to 0: the fl_* data and address registers, pN_dat_o, retry_cnt and wait_cnt.
REQ-035 On that edge, last_grant SHALL go to 1.
REQ-036 A reset during REQ or WAIT SHALL abandon the transaction, with fl_stb_o low the next cycle.

Verification
REQ-037 Port 0 read, adr 0x001000, with the flash model returning 0xDEADBEEF after 40 cycles -> one p0_ack_o pulse, p0_dat_o = 0xDEADBEEF, one fl_stb_o burst.
REQ-038 Both ports request in the same cycle after reset -> port 0 served first, then port 1; on a second simultaneous request, port 1 is served first.
REQ-039 Port 1 erase (we=1, tga=1) with the model giving 3 rty then ack, RETRY_WAIT=16 -> fl_stb_o gaps of 16 cycles, then p1_ack_o; p0 is untouched.
REQ-040 The model always answers rty, MAX_RETRIES=5 -> exactly 5 REQ phases, one p0_err_o pulse, no ack, FSM back in IDLE.
REQ-041 rst_i asserted during WAIT -> all outputs 0 on the next cycle; a fresh request after reset is served normally.
REQ-042 Port 0 drops stb during REQ -> fl_stb_o is held until fl_ack_i, no p0_ack_o, and port 1's pending request is granted next.
